sd_block_server: RTL and testbench

//  Responder end of the sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_* block protocol. Serves 512-byte

---
 rtl/sd_block_pkg.sv | 19 +
 rtl/sd_block_server.sv | 150 +++++++++++++++
 tb/tb_sd_block_server.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_block_pkg.sv
// Shared definitions for the sd_lba/sd_rd/sd_wr/sd_ack block protocol:
// block geometry and the responder state encoding.
package sd_block_pkg;

    localparam int unsigned BLOCK_BYTES = 512;
    localparam int unsigned OFFS_W      = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RD_FETCH,
        ST_RD_PUT,
        ST_WR_ADDR,
        ST_WR_CAPT,
        ST_WR_STORE,
        ST_DONE
    } sd_state_t;

endpackage

// File: rtl/sd_block_server.sv
// Responder for 512-byte block reads/writes, serving a requester buffer from a
// byte-wide backing memory; out-of-range blocks read as zero and drop writes.
module sd_block_server
    import sd_block_pkg::*;
#(
    parameter int unsigned AW        = 24,
    parameter int unsigned ACK_DELAY = 2
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic [31:0]   sd_lba,
    input  logic          sd_rd,
    input  logic          sd_wr,
    input  logic [31:0]   img_blocks,
    output logic          sd_ack,
    output logic [8:0]    sd_buff_addr,
    output logic [7:0]    sd_buff_dout,
    output logic          sd_buff_wr,
    input  logic [7:0]    sd_buff_din,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [7:0]    mem_dout,
    input  logic [7:0]    mem_din,
    input  logic          mem_ready,
    output logic          busy
);

    localparam int unsigned DLY_W = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;

    sd_state_t          r_state;
    sd_state_t          w_next;
    logic [OFFS_W-1:0]  r_offset;
    logic [31:0]        r_lba;
    logic               r_is_wr;
    logic               r_oor;
    logic [7:0]         r_data;
    logic               r_ack;
    logic [DLY_W-1:0]   r_dly;
    logic               w_req;
    logic               w_last;
    logic               w_dly_done;
    logic               w_step;

    assign w_req      = sd_rd | sd_wr;
    assign w_last     = (r_offset == OFFS_W'(BLOCK_BYTES - 1));
    assign w_dly_done = (r_dly == DLY_W'(ACK_DELAY - 1));
    // Out-of-range transfers never touch memory, so they advance without mem_ready.
    assign w_step     = r_oor | mem_ready;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_req) w_next = ST_WAIT;
            ST_WAIT:     if (w_dly_done) w_next = r_is_wr ? ST_WR_ADDR : ST_RD_FETCH;
            ST_RD_FETCH: if (w_step) w_next = ST_RD_PUT;
            ST_RD_PUT:   w_next = w_last ? ST_DONE : ST_RD_FETCH;
            ST_WR_ADDR:  w_next = ST_WR_CAPT;
            ST_WR_CAPT:  w_next = ST_WR_STORE;
            ST_WR_STORE: if (w_step) w_next = w_last ? ST_DONE : ST_WR_ADDR;
            ST_DONE:     w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        sd_buff_wr = 1'b0;
        case (r_state)
            ST_RD_FETCH: mem_rd     = ~r_oor;
            ST_RD_PUT:   sd_buff_wr = 1'b1;
            ST_WR_STORE: mem_wr     = ~r_oor;
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_offset <= '0;
            r_lba    <= '0;
            r_is_wr  <= 1'b0;
            r_oor    <= 1'b0;
            r_data   <= '0;
            r_ack    <= 1'b0;
            r_dly    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_lba    <= sd_lba;
                        r_is_wr  <= ~sd_rd;
                        r_oor    <= (sd_lba >= img_blocks);
                        r_offset <= '0;
                        r_dly    <= '0;
                    end
                end
                ST_WAIT: begin
                    if (w_dly_done) begin
                        r_ack <= 1'b1;
                    end else begin
                        r_dly <= r_dly + 1'b1;
                    end
                end
                ST_RD_FETCH: begin
                    if (r_oor) begin
                        r_data <= '0;
                    end else if (mem_ready) begin
                        r_data <= mem_din;
                    end
                end
                ST_RD_PUT: begin
                    if (w_last) begin
                        r_ack <= 1'b0;
                    end else begin
                        r_offset <= r_offset + 1'b1;
                    end
                end
                ST_WR_CAPT: r_data <= sd_buff_din;
                ST_WR_STORE: begin
                    if (w_step) begin
                        if (w_last) begin
                            r_ack <= 1'b0;
                        end else begin
                            r_offset <= r_offset + 1'b1;
                        end
                    end
                end
                ST_DONE: r_offset <= '0;
                default: ;
            endcase
        end
    end

    assign sd_ack       = r_ack;
    assign sd_buff_addr = r_offset;
    assign sd_buff_dout = r_data;
    assign mem_dout     = r_data;
    assign mem_addr     = AW'({r_lba, r_offset});
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sd_block_server.sv
// Bench for sd_block_server: behavioural backing memory with random stalls,
// registered requester buffer, table of block transfers plus reset/back-to-back sequences.
module tb_sd_block_server;
    import sd_block_pkg::*;

    localparam int unsigned AW        = 24;
    localparam int unsigned ACK_DELAY = 2;
    localparam int unsigned MEM_BYTES = 8192;
    localparam int unsigned BOUND     = 20000;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic [31:0]   sd_lba;
    logic          sd_rd;
    logic          sd_wr;
    logic [31:0]   img_blocks;
    logic          sd_ack;
    logic [8:0]    sd_buff_addr;
    logic [7:0]    sd_buff_dout;
    logic          sd_buff_wr;
    logic [7:0]    sd_buff_din;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [7:0]    mem_dout;
    logic [7:0]    mem_din;
    logic          mem_ready;
    logic          busy;

    always #5 clk_sys = ~clk_sys;

    sd_block_server #(.AW(AW), .ACK_DELAY(ACK_DELAY)) dut (
        .clk_sys(clk_sys), .reset(reset), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .img_blocks(img_blocks), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
        .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_dout(mem_dout),
        .mem_din(mem_din), .mem_ready(mem_ready), .busy(busy)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Backing memory, requester buffers and bench-side expectation image
    logic [7:0]  mem     [0:MEM_BYTES-1];
    logic [7:0]  exp_mem [0:MEM_BYTES-1];
    logic [7:0]  rbuf    [0:511];
    logic [7:0]  wbuf    [0:511];
    int unsigned max_stall = 0;
    int unsigned stall_cnt, stall_tgt;
    int unsigned mem_rd_cnt = 0, mem_wr_cnt = 0, put_cnt = 0, viol = 0, order_err = 0;
    logic          snap_valid;
    logic [AW-1:0] snap_addr;
    logic          snap_rd, snap_wr;
    logic [7:0]    snap_dout;
    logic [8:0]    exp_put_addr;
    logic          chk_stab, chk_both, chk_range, chk_noack;

    assign mem_ready = (mem_rd || mem_wr) && (stall_cnt == stall_tgt);
    assign mem_din   = mem[mem_addr[12:0]];
    assign chk_stab  = snap_valid && (mem_addr !== snap_addr || mem_rd !== snap_rd ||
                                      mem_wr !== snap_wr || mem_dout !== snap_dout);
    assign chk_both  = mem_rd && mem_wr;
    assign chk_range = (mem_rd || mem_wr) && (mem_addr[AW-1:13] != '0);
    assign chk_noack = (mem_rd || mem_wr || sd_buff_wr) && !sd_ack;

    always @(posedge clk_sys) sd_buff_din <= wbuf[sd_buff_addr];

    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            stall_cnt    <= 0;
            stall_tgt    <= 0;
            snap_valid   <= 1'b0;
            exp_put_addr <= '0;
            for (int a = 0; a < int'(MEM_BYTES); a++) begin
                mem[a] <= 8'(a) ^ 8'(a >> 8);
            end
        end else begin
            viol <= viol + int'(chk_stab) + int'(chk_both) + int'(chk_range) + int'(chk_noack);
            if (mem_rd || mem_wr) begin
                if (mem_ready) begin
                    if (mem_wr) begin
                        mem[mem_addr[12:0]] <= mem_dout;
                        mem_wr_cnt <= mem_wr_cnt + 1;
                    end else begin
                        mem_rd_cnt <= mem_rd_cnt + 1;
                    end
                    stall_cnt  <= 0;
                    stall_tgt  <= (max_stall == 0) ? 0 : $urandom_range(max_stall, 0);
                    snap_valid <= 1'b0;
                end else begin
                    stall_cnt  <= stall_cnt + 1;
                    snap_valid <= 1'b1;
                    snap_addr  <= mem_addr;
                    snap_rd    <= mem_rd;
                    snap_wr    <= mem_wr;
                    snap_dout  <= mem_dout;
                end
            end else begin
                snap_valid <= 1'b0;
            end
            if (sd_buff_wr) begin
                if (sd_buff_addr != exp_put_addr) order_err <= order_err + 1;
                exp_put_addr        <= sd_buff_addr + 9'd1;
                rbuf[sd_buff_addr]  <= sd_buff_dout;
                put_cnt             <= put_cnt + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int unsigned cyc = 0;
        while (busy && cyc < BOUND) begin
            @(negedge clk_sys);
            cyc++;
        end
        check("return to idle", 32'(busy), 32'd0);
        @(negedge clk_sys);
    endtask

    typedef struct {
        bit          is_wr;
        bit          both;
        logic [31:0] lba;
        logic [31:0] blocks;
        int unsigned stall;
        logic [7:0]  key;
        int unsigned exp_puts;
        int unsigned exp_rds;
        int unsigned exp_wrs;
    } vec_t;

    task automatic run_xfer(input vec_t v, input string tag);
        int unsigned rd0 = mem_rd_cnt, wr0 = mem_wr_cnt, put0 = put_cnt;
        int unsigned ov0 = viol, oe0 = order_err;
        int unsigned cyc, bad, base;
        bit          oor, prev_put;
        logic [7:0]  e;
        oor  = (v.lba >= v.blocks);
        base = v.lba * 512;
        max_stall = v.stall;
        for (int i = 0; i < 512; i++) wbuf[i] = ~8'(i) ^ v.key;
        wait_idle();
        sd_lba = v.lba; img_blocks = v.blocks;
        sd_rd = !v.is_wr || v.both;
        sd_wr = v.is_wr || v.both;
        cyc = 0;
        while (!sd_ack && cyc < 50) begin
            @(negedge clk_sys);
            cyc++;
        end
        check({tag, " ack latency"}, cyc, ACK_DELAY + 1);
        // Request lines and sampled inputs must be ignored once the transfer is running
        sd_rd = 0; sd_wr = 0; sd_lba = 32'd0; img_blocks = 32'd0;
        cyc = 0; prev_put = 0;
        while (sd_ack && cyc < BOUND) begin
            prev_put = sd_buff_wr && (sd_buff_addr == 9'd511);
            @(negedge clk_sys);
            cyc++;
        end
        check({tag, " ack fall"}, 32'(sd_ack), 32'd0);
        if (!v.is_wr || v.both) check({tag, " ack low after byte 511"}, 32'(prev_put), 32'd1);
        check({tag, " buff_wr count"}, put_cnt - put0, v.exp_puts);
        check({tag, " mem_rd count"}, mem_rd_cnt - rd0, v.exp_rds);
        check({tag, " mem_wr count"}, mem_wr_cnt - wr0, v.exp_wrs);
        bad = 0;
        if (!v.is_wr || v.both) begin
            for (int i = 0; i < 512; i++) begin
                e = oor ? 8'h00 : exp_mem[base + i];
                if (rbuf[i] !== e) bad++;
            end
        end else begin
            if (!oor) for (int i = 0; i < 512; i++) exp_mem[base + i] = ~8'(i) ^ v.key;
            for (int a = 0; a < int'(MEM_BYTES); a++) if (mem[a] !== exp_mem[a]) bad++;
        end
        check({tag, " data bytes wrong"}, bad, 32'd0);
        check({tag, " protocol violations"}, viol - ov0, 32'd0);
        check({tag, " buff addr order"}, order_err - oe0, 32'd0);
    endtask

    vec_t vecs[10];

    initial begin
        int unsigned cyc, p0, low_cnt, idle_cnt;
        vec_t r3;
        vecs[0] = '{is_wr:0, both:0, lba:3, blocks:8, stall:0, key:8'h00, exp_puts:512, exp_rds:512, exp_wrs:0};
        vecs[1] = '{is_wr:1, both:0, lba:1, blocks:8, stall:0, key:8'h00, exp_puts:0,   exp_rds:0,   exp_wrs:512};
        vecs[2] = '{is_wr:0, both:0, lba:8, blocks:8, stall:0, key:8'h00, exp_puts:512, exp_rds:0,   exp_wrs:0};
        vecs[3] = '{is_wr:1, both:0, lba:8, blocks:8, stall:0, key:8'h00, exp_puts:0,   exp_rds:0,   exp_wrs:0};
        vecs[4] = '{is_wr:0, both:0, lba:1, blocks:8, stall:5, key:8'h00, exp_puts:512, exp_rds:512, exp_wrs:0};
        vecs[5] = '{is_wr:1, both:0, lba:2, blocks:8, stall:5, key:8'h5A, exp_puts:0,   exp_rds:0,   exp_wrs:512};
        vecs[6] = '{is_wr:0, both:1, lba:2, blocks:8, stall:3, key:8'h00, exp_puts:512, exp_rds:512, exp_wrs:0};
        vecs[7] = '{is_wr:0, both:0, lba:0, blocks:0, stall:0, key:8'h00, exp_puts:512, exp_rds:0,   exp_wrs:0};
        vecs[8] = '{is_wr:1, both:0, lba:7, blocks:8, stall:2, key:8'h3C, exp_puts:0,   exp_rds:0,   exp_wrs:512};
        vecs[9] = '{is_wr:0, both:0, lba:7, blocks:8, stall:1, key:8'h00, exp_puts:512, exp_rds:512, exp_wrs:0};
        for (int a = 0; a < int'(MEM_BYTES); a++) exp_mem[a] = 8'(a) ^ 8'(a >> 8);
        for (int i = 0; i < 512; i++) wbuf[i] = ~8'(i);

        reset = 1; sd_lba = 0; sd_rd = 0; sd_wr = 0; img_blocks = 0;
        repeat (3) @(negedge clk_sys);
        check("reset sd_ack", 32'(sd_ack), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset mem_rd/mem_wr", {30'd0, mem_rd, mem_wr}, 32'd0);
        check("reset sd_buff_wr", 32'(sd_buff_wr), 32'd0);
        check("reset sd_buff_addr", 32'(sd_buff_addr), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        reset = 0;
        @(negedge clk_sys);

        // Reset while a read fetch is outstanding
        p0 = put_cnt;
        sd_lba = 3; img_blocks = 8; sd_rd = 1;
        cyc = 0;
        while (!sd_ack && cyc < 50) begin @(negedge clk_sys); cyc++; end
        sd_rd = 0;
        cyc = 0;
        while (!((put_cnt - p0) >= 100 && mem_rd) && cyc < BOUND) begin @(negedge clk_sys); cyc++; end
        check("reached byte 100 with mem_rd", 32'(mem_rd), 32'd1);
        #2 reset = 1;
        #1;
        check("async reset sd_ack", 32'(sd_ack), 32'd0);
        check("async reset mem_rd", 32'(mem_rd), 32'd0);
        check("async reset busy", 32'(busy), 32'd0);
        @(negedge clk_sys);
        reset = 0;
        r3 = vecs[0];
        run_xfer(r3, "after reset");

        for (int k = 0; k < 10; k++) run_xfer(vecs[k], $sformatf("v%0d", k));

        // Back-to-back: second read raised on the cycle ack falls
        wait_idle();
        max_stall = 0;
        p0 = put_cnt;
        sd_lba = 3; img_blocks = 8; sd_rd = 1;
        cyc = 0;
        while (!sd_ack && cyc < 50) begin @(negedge clk_sys); cyc++; end
        sd_rd = 0;
        cyc = 0;
        while (sd_ack && cyc < BOUND) begin @(negedge clk_sys); cyc++; end
        sd_rd = 1;
        low_cnt = 0; idle_cnt = 0;
        while (!sd_ack && low_cnt < 50) begin
            low_cnt++;
            if (!busy) idle_cnt++;
            @(negedge clk_sys);
        end
        sd_rd = 0;
        // Low window = DONE cycle + IDLE cycle that samples the request + ACK_DELAY
        check("b2b ack low cycles", low_cnt, ACK_DELAY + 2);
        check("b2b idle cycles", idle_cnt, 32'd1);
        cyc = 0;
        while (sd_ack && cyc < BOUND) begin @(negedge clk_sys); cyc++; end
        check("b2b total buff_wr", put_cnt - p0, 32'd1024);
        check("b2b final protocol violations", viol, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
